// File: rtl/bram_controller_if.sv
// Bus bundle for the sequential BRAM access sequencer: burst control inputs
// and the EMIF-style memory port outputs.
interface bram_controller_if #(
  parameter int ADDR_SIZE = 16
);
  logic [31:0]          i_Length;
  logic                 i_Mode;
  logic                 i_Trig;
  logic [ADDR_SIZE-1:0] o_Addr;
  logic                 o_EN;
  logic [1:0]           o_WEN;
  logic                 o_Busy;
  logic                 o_Done;

  // Driver side (system / bench) issues bursts and observes the memory port.
  modport master (
    output i_Length, i_Mode, i_Trig,
    input  o_Addr, o_EN, o_WEN, o_Busy, o_Done
  );

  // Controller side.
  modport slave (
    input  i_Length, i_Mode, i_Trig,
    output o_Addr, o_EN, o_WEN, o_Busy, o_Done
  );
endinterface

// File: rtl/bram_controller.sv
// Sequential BRAM access sequencer. A clean 0->1 edge on i_Trig starts a
// burst of i_Length one-cycle accesses at addresses 0,1,2,... (wrapping at
// 2^ADDR_SIZE), writing or reading according to i_Mode sampled at start.
// All outputs come straight from flops.
module bram_controller #(
  parameter int ADDR_SIZE = 16
) (
  input logic             clk,
  input logic             rst,
  bram_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          len_q, len_d;
  logic                 mode_q, mode_d;
  logic                 trig_q;
  // Set once i_Trig has been seen low after reset, so a trigger that is
  // already high when reset releases is not mistaken for a fresh edge.
  logic                 armed_q;
  logic                 start;

  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 en_q, en_d;
  logic [1:0]           wen_q, wen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign start = bus.i_Trig & ~trig_q & armed_q;

  // Control state, burst parameters and trigger edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      trig_q  <= bus.i_Trig;
      armed_q <= armed_q | ~bus.i_Trig;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    addr_d  = '0;
    en_d    = 1'b0;
    wen_d   = 2'b00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = bus.i_Length;
          mode_d  = bus.i_Mode;
          cnt_d   = '0;
          state_d = (bus.i_Length == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        en_d   = 1'b1;
        addr_d = cnt_q[ADDR_SIZE-1:0];
        wen_d  = {2{mode_q}};
        busy_d = 1'b1;
        cnt_d  = cnt_q + 32'd1;
        // Full 32-bit compare so bursts longer than the address space
        // still issue exactly len accesses.
        if (cnt_q == len_q - 32'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers: memory port and status lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      en_q   <= 1'b0;
      wen_q  <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      en_q   <= en_d;
      wen_q  <= wen_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.o_Addr = addr_q;
  assign bus.o_EN   = en_q;
  assign bus.o_WEN  = wen_q;
  assign bus.o_Busy = busy_q;
  assign bus.o_Done = done_q;

endmodule

// File: tb/tb_bram_controller.sv
// Scoreboard bench for bram_controller. Each burst issued pushes its expected
// accesses (cycle, address, write enables) and its Done cycle into queues; a
// monitor on the falling edge pops and compares whenever the DUT shows o_EN
// or o_Done, and checks o_Busy against the expected burst window every cycle.
module tb_bram_controller;

  localparam int AW = 4;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [1:0]    wen;
  } acc_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errs;
  int   checks;
  bit   mon_en;
  int   busy_lo;
  int   busy_hi;

  acc_t acc_q[$];
  int   done_q[$];

  bram_controller_if #(.ADDR_SIZE(AW)) bus ();

  bram_controller #(.ADDR_SIZE(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges so far; at a falling edge it names the output cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    acc_t e;
    int   d;
    if (mon_en) begin
      if (bus.o_EN) begin
        if (acc_q.size() == 0) begin
          check("unexpected_en", 64'(bus.o_EN), 64'd0);
        end else begin
          e = acc_q.pop_front();
          check("acc_cycle", 64'(cyc), 64'(e.cyc));
          check("acc_addr", 64'(bus.o_Addr), 64'(e.addr));
          check("acc_wen", 64'(bus.o_WEN), 64'(e.wen));
          $display("access cyc=%0d addr=%0d wen=%b", cyc, bus.o_Addr, bus.o_WEN);
        end
      end else begin
        check("idle_addr_wen", {58'd0, bus.o_Addr, bus.o_WEN}, 64'd0);
      end
      if (bus.o_Done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(bus.o_Done), 64'd0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d));
          $display("done cyc=%0d", cyc);
        end
      end
      check("busy", 64'(bus.o_Busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
    end
  end

  // Issue one burst: the trigger rises at a cycle boundary, access k is
  // expected two output cycles later plus k, Done right after the last one.
  task automatic burst(input int len, input bit mode, input bit toggle, input int hold);
    int   n;
    acc_t e;
    @(negedge clk); #2;
    bus.i_Trig = 1'b0;
    @(negedge clk); #2;
    bus.i_Length = len;
    bus.i_Mode   = mode;
    bus.i_Trig   = 1'b1;
    n = cyc;
    for (int k = 0; k < len; k++) begin
      e.cyc  = n + 2 + k;
      e.addr = AW'(k % (1 << AW));
      e.wen  = {2{mode}};
      acc_q.push_back(e);
    end
    done_q.push_back(n + 2 + len);
    busy_lo = n + 2;
    busy_hi = n + 2 + len;
    $display("burst len=%0d mode=%0d toggle=%0d hold=%0d start_cyc=%0d", len, mode, toggle, hold, n);
    repeat (len + 2 + hold) begin
      @(negedge clk); #2;
      if (toggle) begin
        bus.i_Mode   = 1'($urandom);
        bus.i_Length = $urandom;
      end
    end
    bus.i_Trig = 1'b0;
    check("drain_acc", 64'(acc_q.size()), 64'd0);
    check("drain_done", 64'(done_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    acc_t e;
    cyc      = 0;
    errs     = 0;
    checks   = 0;
    mon_en   = 1'b0;
    busy_lo  = 0;
    busy_hi  = -1;
    rst      = 1'b0;
    bus.i_Length = '0;
    bus.i_Mode   = 1'b0;
    bus.i_Trig   = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("reset_outputs", {57'd0, bus.o_Addr, bus.o_EN, bus.o_WEN}, 64'd0);
    check("reset_status", {62'd0, bus.o_Busy, bus.o_Done}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    burst(10, 1'b1, 1'b0, 0);   // write burst
    burst(10, 1'b0, 1'b0, 0);   // read burst
    burst(4, 1'b1, 1'b0, 100);  // trigger held high afterwards: one burst only
    burst(4, 1'b0, 1'b0, 0);    // second clean edge: second burst
    burst(0, 1'b1, 1'b0, 0);    // zero length: Done only
    burst(20, 1'b1, 1'b1, 0);   // wrap past 16 with inputs churning mid-burst

    // Reset in the middle of a 10-access burst.
    @(negedge clk); #2;
    bus.i_Trig = 1'b0;
    @(negedge clk); #2;
    bus.i_Length = 10;
    bus.i_Mode   = 1'b1;
    bus.i_Trig   = 1'b1;
    n = cyc;
    for (int k = 0; k < 10; k++) begin
      e.cyc  = n + 2 + k;
      e.addr = AW'(k);
      e.wen  = 2'b11;
      acc_q.push_back(e);
    end
    done_q.push_back(n + 12);
    busy_lo = n + 2;
    busy_hi = n + 12;
    $display("burst len=10 mode=1 with reset at access 5 start_cyc=%0d", n);
    repeat (7) @(negedge clk);
    #2;
    check("mid_reset_seen_acc5", 64'(10 - acc_q.size()), 64'd6);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {57'd0, bus.o_Addr, bus.o_EN, bus.o_WEN}, 64'd0);
    check("mid_reset_status", {62'd0, bus.o_Busy, bus.o_Done}, 64'd0);
    acc_q.delete();
    done_q.delete();
    busy_hi = -1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;               // trigger still high across release
    repeat (8) @(negedge clk);   // monitor flags any access or Done here
    #2;
    bus.i_Trig = 1'b0;
    burst(3, 1'b0, 1'b0, 0);     // fresh trigger restarts at address 0

    for (int r = 0; r < 10; r++) begin
      burst(int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
